uart_transmitter: RTL and testbench

Serial UART transmitter: accepts one byte per handshake from on-chip logic and shifts it out as one start bit, 8 data bits LSB first, and one stop bit. An optional parity bit can be compiled in. Bit period is set at run time by a 16-bit clocks-per-bit input, so software can program the baud rate. It is the TX half of the SoC UART and drives the pad-side serial line that pairs with `uart_receiver`.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_transmitter.sv | 149 ++++++++++++++
 tb/tb_uart_transmitter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame sizes, common to the TX and RX halves.
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_CLEANUP = 3'd4;
    localparam logic [2:0] ST_PARITY  = 3'd5;

    localparam int unsigned UART_DATA_BITS         = 8;
    localparam int unsigned UART_FRAME_BITS        = 10;
    localparam int unsigned UART_FRAME_BITS_PARITY = 11;
    localparam logic [2:0]  UART_LAST_DATA_IDX     = 3'd7;

    function automatic logic uart_even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..cpb-1 and pulses bit_end_o on the last count of each bit.
module uart_bit_timer (
    input  logic        i_Clock,
    input  logic        rst_i,
    input  logic [15:0] cpb_i,
    input  logic        clear_i,
    output logic        bit_end_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] last_cnt;

    always_comb begin
        last_cnt  = (cpb_i == 16'd0) ? 16'd0 : cpb_i - 16'd1;
        bit_end_o = !clear_i && (cnt_q == last_cnt);
        cnt_d     = (clear_i || bit_end_o) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART TX: start bit, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop bit.
// state   | meaning
// IDLE    | line high, ready for a byte
// START   | start bit (low)
// DATA    | data bit idx
// PARITY  | even parity bit (UART_TX_PARITY_EN only)
// STOP    | stop bit (high)
// CLEANUP | one-cycle done pulse, not ready
module uart_transmitter
    import uart_pkg::*;
(
    input  logic        i_Clock,
    input  logic        rst_i,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic        i_Tx_DV,
    input  logic [7:0]  i_Tx_Byte,
    output logic        o_Tx_Ready,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done
);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] cpb_q, cpb_d;
    logic        serial_q, serial_d;
    logic        ready_q, ready_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        timer_clear;
    logic        bit_end;

    uart_bit_timer u_bit_timer (
        .i_Clock   (i_Clock),
        .rst_i     (rst_i),
        .cpb_i     (cpb_q),
        .clear_i   (timer_clear),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        cpb_d       = cpb_q;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_clear = 1'b1;
                if (i_Tx_DV && ready_q) begin
                    state_d = ST_START;
                    byte_d  = i_Tx_Byte;
                    cpb_d   = (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
                    idx_d   = 3'd0;
                end
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == UART_LAST_DATA_IDX) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) state_d = ST_CLEANUP;
            end
            ST_CLEANUP: begin
                timer_clear = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                timer_clear = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        serial_d = 1'b1;
        ready_d  = 1'b0;
        active_d = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_IDLE:    ready_d = 1'b1;
            ST_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            ST_DATA: begin
                serial_d = byte_d[idx_d];
                active_d = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                serial_d = uart_even_parity(byte_d);
                active_d = 1'b1;
            end
`endif
            ST_STOP:    active_d = 1'b1;
            ST_CLEANUP: done_d   = 1'b1;
            default:    ready_d  = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            byte_q   <= 8'd0;
            cpb_q    <= 16'd1;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            cpb_q    <= cpb_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Ready  = ready_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of frames plus handshake, CPB-change and reset-abort sequences.
module tb_uart_transmitter;

    logic        i_Clock = 1'b0;
    logic        rst_i   = 1'b1;
    logic [15:0] cpb_in  = 16'd4;
    logic        dv      = 1'b0;
    logic [7:0]  tx_byte = 8'h00;
    logic        o_Tx_Ready;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;

    int checks = 0;
    int passed = 0;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    uart_transmitter dut (
        .i_Clock      (i_Clock),
        .rst_i        (rst_i),
        .CLKS_PER_BIT (cpb_in),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (tx_byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic [15:0] cpb;
        int          eff;
        logic [7:0]  data;
        logic        par;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic par, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (NBITS == 11 && b == 9) return par;
        return 1'b1;
    endfunction

    // Assumes the accept edge was the last posedge; checks {serial,active,ready,done} every cycle.
    task automatic run_frame(input int cpb, input logic [7:0] d, input logic par, input string name);
        for (int k = 1; k <= NBITS * cpb; k++) begin
            @(negedge i_Clock);
            chk({name, "_bit"}, {28'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done},
                {28'd0, exp_bit(d, par, (k - 1) / cpb), 1'b1, 1'b0, 1'b0});
        end
        @(negedge i_Clock);
        chk({name, "_done"}, {28'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done}, 32'b1001);
        @(negedge i_Clock);
        chk({name, "_ready"}, {28'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done}, 32'b1010);
    endtask

    task automatic send(input logic [15:0] cpb, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge i_Clock);
        while (!o_Tx_Ready && n < 500) begin
            @(negedge i_Clock);
            n++;
        end
        if (n >= 500) chk("ready_timeout", 32'd0, 32'd1);
        cpb_in  = cpb;
        tx_byte = d;
        dv      = 1'b1;
        @(posedge i_Clock);
        #1 dv = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0] = '{16'd4, 4, 8'hA5, 1'b0};
        vecs[1] = '{16'd0, 1, 8'h3C, 1'b0};
        vecs[2] = '{16'd1, 1, 8'h3C, 1'b0};
        vecs[3] = '{16'd3, 3, 8'h01, 1'b1};
        vecs[4] = '{16'd2, 2, 8'hFF, 1'b0};

        // Reset held with a pending request: nothing accepted until reset drops.
        rst_i   = 1'b1;
        dv      = 1'b1;
        tx_byte = 8'h55;
        cpb_in  = 16'd2;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        chk("reset_outputs", {28'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done}, 32'b1010);
        rst_i = 1'b0;
        @(posedge i_Clock);
        #1 dv = 1'b0;
        run_frame(2, 8'h55, 1'b0, "rst_release");

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].cpb, vecs[i].data);
            run_frame(vecs[i].eff, vecs[i].data, vecs[i].par, "vec");
        end

        // Request held high across two bytes.
        @(negedge i_Clock);
        cpb_in  = 16'd4;
        tx_byte = 8'h00;
        dv      = 1'b1;
        @(posedge i_Clock);
        #1 tx_byte = 8'hFF;
        run_frame(4, 8'h00, 1'b0, "b2b_first");
        @(posedge i_Clock);
        #1 dv = 1'b0;
        run_frame(4, 8'hFF, 1'b0, "b2b_second");
        seen = 0;
        repeat (20) begin
            @(negedge i_Clock);
            if (o_Tx_Active || !o_Tx_Ready) seen++;
        end
        chk("no_extra_frame", seen, 32'd0);

        // CPB changed mid-frame only affects the next frame.
        send(16'd4, 8'h96);
        fork
            run_frame(4, 8'h96, 1'b0, "cpb_hold");
            begin
                repeat (10) @(negedge i_Clock);
                cpb_in = 16'd8;
            end
        join
        send(16'd8, 8'h3C);
        run_frame(8, 8'h3C, 1'b0, "cpb_next");

        // Reset pulse during data bit 3.
        send(16'd4, 8'hA5);
        repeat (18) @(negedge i_Clock);
        chk("data_bit3", {31'd0, o_Tx_Serial}, 32'd0);
        rst_i = 1'b1;
        @(posedge i_Clock);
        #1 rst_i = 1'b0;
        @(negedge i_Clock);
        chk("reset_abort", {28'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Ready, o_Tx_Done}, 32'b1010);
        seen = 0;
        repeat (60) begin
            @(negedge i_Clock);
            if (o_Tx_Done || o_Tx_Active) seen++;
        end
        chk("no_done_after_abort", seen, 32'd0);
        send(16'd4, 8'hA5);
        run_frame(4, 8'hA5, 1'b0, "after_abort");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
